// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit XNOR PRBS (taps 7 and 10) generator and checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 10;
  localparam int unsigned TAP_A  = 6;
  localparam int unsigned TAP_B  = 9;
  localparam int unsigned SEED_W = $clog2(LFSR_W + 1);

  localparam logic [LFSR_W-1:0] LOCKUP_STATE = 10'h3FF;

  typedef enum logic {HUNT, LOCKED} chk_state_t;

  // hist[0] is the newest bit; the result is the next bit in the stream.
  function automatic logic lfsr_pred(input logic [LFSR_W-1:0] h);
    return ~(h[TAP_A] ^ h[TAP_B]);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-seeds from the stream, then compares it
// against a free-running local predictor and tracks errors and lock.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned WIN_W = $clog2(WIN_LEN + 1);
  localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

  chk_state_t        state;
  logic [LFSR_W-1:0] hist;
  logic [LFSR_W-1:0] seed_next;
  logic [SEED_W-1:0] seed_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  win_err;
  logic              pred;
  logic              check_en;
  logic              mismatch;

  always_comb begin
    pred      = lfsr_pred(hist);
    check_en  = in_valid && (state == LOCKED);
    mismatch  = check_en && (in_bit != pred);
    seed_next = {hist[LFSR_W-2:0], in_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      hist      <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            hist <= seed_next;
            if (seed_cnt == SEED_W'(LFSR_W - 1)) begin
              seed_cnt <= '0;
              if (seed_next != LOCKUP_STATE) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              seed_cnt <= seed_cnt + SEED_W'(1);
            end
          end
          LOCKED: begin
            // Shift the prediction, not the received bit, so one flipped bit costs one error.
            hist      <= {hist[LFSR_W-2:0], pred};
            err_pulse <= mismatch;
            if (mismatch && (win_err == ERR_W'(ERR_THRESH - 1))) begin
              state    <= HUNT;
              locked   <= 1'b0;
              seed_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              win_err <= win_err + ERR_W'(mismatch);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch),
    .clr   (clear_cnt),
    .q     (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_count (
    .clk   (clk),
    .reset (reset),
    .inc   (check_en),
    .clr   (clear_cnt),
    .q     (bit_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed vectors push expected outputs,
// a negedge monitor pops and compares them one cycle later.
module tb_lfsr_checker;

  localparam int unsigned CNT_W = 10;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear_cnt = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  lfsr_checker #(.CNT_W(CNT_W), .WIN_LEN(64), .ERR_THRESH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic lk;
    logic ep;
    int   ec;
    int   bc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nchecks = 0;
  int   nerr = 0;

  logic [9:0] g;
  logic       e_lk;
  int         e_ec;
  int         e_bc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("locked", int'(locked), int'(e.lk));
      chk("err_pulse", int'(err_pulse), int'(e.ep));
      chk("err_count", int'(err_count), e.ec);
      chk("bit_count", int'(bit_count), e.bc);
    end
  end

  function automatic int sat(input int x);
    return (x >= MAXC) ? MAXC : x + 1;
  endfunction

  function automatic logic nxt();
    return ~(g[6] ^ g[9]);
  endfunction

  // Called just after a rising edge; outputs are expected after the next one.
  task automatic drive(input logic r, input logic v, input logic b, input logic c,
                       input logic lk, input logic ep, input int ec, input int bc);
    reset = r; in_valid = v; in_bit = b; clear_cnt = c;
    sb.push_back('{cyc + 1, lk, ep, ec, bc});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    e_lk = 1'b0; e_ec = 0; e_bc = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic seed_zero();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) e_lk = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b0, e_lk, 1'b0, e_ec, e_bc);
    end
    g = '0;
  endtask

  task automatic seed_ones();
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_ec, e_bc);
  endtask

  task automatic seed_gen();
    logic b;
    for (int i = 0; i < 10; i++) begin
      b = nxt(); g = {g[8:0], b};
      if (i == 9) e_lk = 1'b1;
      drive(1'b0, 1'b1, b, 1'b0, e_lk, 1'b0, e_ec, e_bc);
    end
  endtask

  task automatic good(input logic v, input logic c);
    logic b;
    if (v) begin
      b = nxt(); g = {g[8:0], b};
    end else begin
      b = 1'($urandom_range(1));
    end
    if (c) begin
      e_ec = 0; e_bc = 0;
    end else if (v) begin
      e_bc = sat(e_bc);
    end
    drive(1'b0, v, b, c, e_lk, 1'b0, e_ec, e_bc);
  endtask

  task automatic bad(input logic c, input logic drop);
    logic b;
    b = ~nxt(); g = {g[8:0], ~b};
    if (c) begin
      e_ec = 0; e_bc = 0;
    end else begin
      e_ec = sat(e_ec); e_bc = sat(e_bc);
    end
    if (drop) e_lk = 1'b0;
    drive(1'b0, 1'b1, b, c, e_lk, 1'b1, e_ec, e_bc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    g = '0; e_lk = 1'b0; e_ec = 0; e_bc = 0;
    @(posedge clk); #1;

    // Zero seed, first correct bit, then one injected error.
    do_reset();
    seed_zero();
    good(1'b1, 1'b0);
    bad(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) good(1'b1, 1'b0);

    // Lock-up seed is rejected, zero seed is then accepted; long stream saturates bit_count.
    do_reset();
    seed_ones();
    seed_zero();
    for (int i = 0; i < 2200; i++) good(logic'(i % 2 == 0), 1'b0);

    // Eight errors inside one window drop lock; re-seed from the clean stream.
    do_reset();
    seed_zero();
    for (int p = 0; p < 36; p++) begin
      if (p % 5 == 0) bad(1'b0, logic'(p == 35));
      else good(1'b1, 1'b0);
    end
    seed_gen();
    for (int i = 0; i < 6; i++) good(1'b1, 1'b0);

    // Window rollover clears the error tally; threshold on the window's last bit still drops lock.
    do_reset();
    seed_zero();
    for (int p = 0; p < 128; p++) begin
      if (p < 7 || (p >= 64 && p < 71)) bad(1'b0, 1'b0);
      else if (p == 127) bad(1'b0, 1'b1);
      else good(1'b1, 1'b0);
    end

    // Reset mid-lock with five errors counted.
    do_reset();
    seed_zero();
    for (int p = 0; p < 9; p++) begin
      if (p % 2 == 0) bad(1'b0, 1'b0);
      else good(1'b1, 1'b0);
    end
    do_reset();
    seed_zero();

    // clear_cnt wins over a coincident error and a coincident valid bit.
    bad(1'b1, 1'b0);
    good(1'b1, 1'b1);
    good(1'b1, 1'b0);
    bad(1'b0, 1'b0);
    good(1'b0, 1'b1);
    good(1'b1, 1'b0);

    in_valid = 1'b0; clear_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchecks++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
